// File: rtl/cpu_io_bridge.sv
// rtl/cpu_io_bridge.sv - far end of the core byte-stream IO: UART RX/TX FIFOs and status vector
// RX FIFO is first-word-fall-through; TX FIFO drains through a start/busy handshake FSM.
module cpu_io_bridge #(
   parameter int RX_AW = 4,
   parameter int TX_AW = 4
) (
   input  logic       clk,
   input  logic       rstn,
   output logic [7:0] io_in_data,
   output logic       io_in_vld,
   input  logic       io_in_rdy,
   input  logic [7:0] io_out_data,
   input  logic       io_out_vld,
   output logic       io_out_rdy,
   output logic [4:0] io_err,
   input  logic       err_clr,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_ferr,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy
);
   localparam logic [RX_AW:0] RX_DEPTH = (RX_AW + 1)'(1 << RX_AW);
   localparam logic [TX_AW:0] TX_DEPTH = (TX_AW + 1)'(1 << TX_AW);

   typedef enum logic [1:0] {T_IDLE, T_ACK, T_DRAIN} tx_state_t;

   logic [7:0]       rx_mem [1 << RX_AW];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic [RX_AW:0]   rx_cnt;
   logic [7:0]       rx_last;
   logic             err_ovf, err_ferr;
   logic             rx_full, rx_pop, rx_push, rx_ovf;

   logic [7:0]       tx_mem [1 << TX_AW];
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic [TX_AW:0]   tx_cnt;
   tx_state_t        tx_state;
   logic             tx_full, tx_push, tx_pop;

   assign rx_full    = (rx_cnt == RX_DEPTH);
   assign io_in_vld  = (rx_cnt != '0);
   assign rx_pop     = io_in_vld & io_in_rdy;
   assign rx_push    = rx_valid & (~rx_full | rx_pop);
   assign rx_ovf     = rx_valid & rx_full & ~rx_pop;
   // Hold the last delivered byte while empty so the core never sees stale RAM.
   assign io_in_data = io_in_vld ? rx_mem[rx_rp] : rx_last;

   always_ff @(posedge clk) begin
      if (rx_push)
         rx_mem[rx_wp] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_cnt   <= '0;
         rx_last  <= '0;
         err_ovf  <= 1'b0;
         err_ferr <= 1'b0;
      end else begin
         if (rx_push)
            rx_wp <= rx_wp + 1'b1;
         if (rx_pop) begin
            rx_rp   <= rx_rp + 1'b1;
            rx_last <= rx_mem[rx_rp];
         end
         rx_cnt   <= rx_cnt + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
         err_ovf  <= rx_ovf | (err_ovf & ~err_clr);
         err_ferr <= rx_ferr | (err_ferr & ~err_clr);
      end
   end

   assign tx_full    = (tx_cnt == TX_DEPTH);
   assign io_out_rdy = ~tx_full;
   assign tx_push    = io_out_vld & io_out_rdy;
   assign tx_pop     = (tx_state == T_IDLE) & (tx_cnt != '0) & ~tx_busy;

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wp] <= io_out_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_state <= T_IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_cnt   <= '0;
      end else begin
         tx_start <= 1'b0;
         if (tx_push)
            tx_wp <= tx_wp + 1'b1;
         if (tx_pop)
            tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
         case (tx_state)
            T_IDLE: begin
               if (tx_pop) begin
                  tx_data  <= tx_mem[tx_rp];
                  tx_start <= 1'b1;
                  tx_state <= T_ACK;
               end
            end
            T_ACK: begin
               if (tx_busy)
                  tx_state <= T_DRAIN;
            end
            T_DRAIN: begin
               if (!tx_busy)
                  tx_state <= T_IDLE;
            end
            default: tx_state <= T_IDLE;
         endcase
      end
   end

   assign io_err = {(tx_cnt == '0) & (tx_state == T_IDLE) & ~tx_busy,
                    io_in_vld, tx_full, err_ferr, err_ovf};

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb/tb_cpu_io_bridge.sv - self-checking bench for cpu_io_bridge
// Table vectors for RX/status, scoreboard queues for both byte streams, UART busy model.
module tb_cpu_io_bridge;
   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] io_in_data;
   logic       io_in_vld;
   logic       io_in_rdy;
   logic [7:0] io_out_data;
   logic       io_out_vld;
   logic       io_out_rdy;
   logic [4:0] io_err;
   logic       err_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy = 1'b0;

   cpu_io_bridge #(.RX_AW(4), .TX_AW(4)) dut (
      .clk(clk), .rstn(rstn),
      .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(io_in_rdy),
      .io_out_data(io_out_data), .io_out_vld(io_out_vld), .io_out_rdy(io_out_rdy),
      .io_err(io_err), .err_clr(err_clr),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   int starts = 0;
   int cyc = 0;
   int last_start = -100;
   logic busy_q = 1'b0;
   logic uart_auto = 1'b1;
   logic force_busy = 1'b0;
   int busy_cnt = 0;

   typedef struct {
      logic       rv;
      logic [7:0] rd;
      logic       fe;
      logic       rdy;
      logic       clr;
      logic       e_vld;
      logic [7:0] e_data;
      logic [4:0] e_err;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) busy_q <= tx_busy;

   // UART transmitter model: busy rises the cycle after tx_start and lasts 10 cycles.
   always @(negedge clk) begin
      if (!uart_auto || !rstn) begin
         busy_cnt = 0;
         tx_busy  = force_busy;
      end else begin
         if (tx_start)
            busy_cnt = 10;
         else if (busy_cnt > 0)
            busy_cnt--;
         tx_busy = (busy_cnt > 0);
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         cyc++;
         if (io_in_vld && io_in_rdy) begin
            if (rx_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rx_unexpected actual=%0h required=none", io_in_data);
            end else
               check("rx_order", io_in_data, rx_q.pop_front());
         end
         if (io_out_vld && io_out_rdy)
            tx_q.push_back(io_out_data);
         if (tx_start) begin
            starts++;
            check("tx_start_spacing_ok", (cyc - last_start >= 3), 1);
            check("tx_start_while_busy", busy_q, 0);
            last_start = cyc;
            if (tx_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else
               check("tx_order", tx_data, tx_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 5'b11000};
      tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 5'b11000};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 5'b11000};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h42, 5'b10000};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h42, 5'b10010};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, 5'b10000};
      tbl[6] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 5'b11010};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 5'b10010};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 5'b10000};

      rstn = 1'b0; io_in_rdy = 0; io_out_data = 0; io_out_vld = 0;
      err_clr = 0; rx_data = 0; rx_valid = 0; rx_ferr = 0;
      repeat (3) tick();
      check("rst_in_vld", io_in_vld, 0);
      check("rst_in_data", io_in_data, 0);
      check("rst_out_rdy", io_out_rdy, 1);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_io_err", io_err, 5'b10000);
      rstn = 1'b1;
      tick();

      // RX delivery, hold-when-empty, sticky ferr vs clear
      for (int i = 0; i < 9; i++) begin
         rx_valid = tbl[i].rv; rx_data = tbl[i].rd; rx_ferr = tbl[i].fe;
         io_in_rdy = tbl[i].rdy; err_clr = tbl[i].clr;
         if (tbl[i].rv) rx_q.push_back(tbl[i].rd);
         tick();
         check($sformatf("vec%0d_vld", i), io_in_vld, tbl[i].e_vld);
         check($sformatf("vec%0d_data", i), io_in_data, tbl[i].e_data);
         check($sformatf("vec%0d_err", i), io_err, tbl[i].e_err);
      end
      rx_valid = 0; rx_ferr = 0; io_in_rdy = 0; err_clr = 0;
      tick();

      // RX overflow
      for (int i = 0; i < 17; i++) begin
         rx_valid = 1; rx_data = 8'(i);
         if (i < 16) rx_q.push_back(8'(i));
         tick();
      end
      rx_valid = 0;
      tick();
      check("ovf_err0", io_err[0], 1);
      check("ovf_head", io_in_data, 8'h00);
      io_in_rdy = 1;
      repeat (16) tick();
      io_in_rdy = 0;
      check("ovf_drained_vld", io_in_vld, 0);
      check("ovf_q_empty", rx_q.size(), 0);
      check("ovf_err0_held", io_err[0], 1);
      err_clr = 1; tick(); err_clr = 0;
      check("ovf_err0_clr", io_err[0], 0);

      // Full RX with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         rx_valid = 1; rx_data = 8'h20 + 8'(i); rx_q.push_back(rx_data);
         tick();
      end
      rx_valid = 1; rx_data = 8'h55; io_in_rdy = 1; rx_q.push_back(8'h55);
      tick();
      rx_valid = 0;
      check("full_pp_no_ovf", io_err[0], 0);
      repeat (15) tick();
      io_in_rdy = 0;
      check("full_pp_vld", io_in_vld, 1);
      check("full_pp_last", io_in_data, 8'h55);
      io_in_rdy = 1; tick(); io_in_rdy = 0;
      check("full_pp_empty", io_in_vld, 0);
      check("full_pp_q", rx_q.size(), 0);

      // TX with UART model
      s0 = starts;
      uart_auto = 1;
      io_out_vld = 1; io_out_data = 8'hA5; tick();
      io_out_data = 8'h5A; tick();
      io_out_vld = 0;
      for (int i = 0; i < 100 && !(starts - s0 == 2 && io_err[4] == 1'b1); i++) tick();
      check("tx_two_starts", starts - s0, 2);
      check("tx_q_empty", tx_q.size(), 0);
      check("tx_last_data", tx_data, 8'h5A);
      check("tx_idle_end", io_err[4], 1);

      // TX FIFO fills while UART stays busy
      uart_auto = 0; force_busy = 1;
      repeat (2) tick();
      for (int i = 0; i < 16; i++) begin
         io_out_vld = 1; io_out_data = 8'h80 + 8'(i);
         tick();
      end
      io_out_vld = 0;
      check("txfull_rdy", io_out_rdy, 0);
      check("txfull_err2", io_err[2], 1);
      check("txfull_err4", io_err[4], 0);
      force_busy = 0; uart_auto = 1;
      @(negedge clk); #1;
      check("txfull_rdy_before_pop", io_out_rdy, 0);
      tick();
      check("txfull_rdy_after_pop", io_out_rdy, 1);
      check("txfull_err2_after", io_err[2], 0);
      for (int i = 0; i < 400 && !(tx_q.size() == 0 && io_err[4] == 1'b1); i++) tick();
      check("txfull_drained", tx_q.size(), 0);
      check("txfull_idle", io_err[4], 1);

      // Reset mid-transfer
      uart_auto = 0; force_busy = 1;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         io_out_vld = 1; io_out_data = 8'hC0 + 8'(i);
         tick();
      end
      io_out_vld = 0;
      rx_valid = 1; rx_data = 8'h99; tick(); rx_valid = 0;
      rstn = 0;
      repeat (2) tick();
      rx_q.delete(); tx_q.delete();
      force_busy = 0;
      rstn = 1;
      s0 = starts;
      repeat (30) tick();
      check("rst_mid_no_start", starts - s0, 0);
      check("rst_mid_in_vld", io_in_vld, 0);
      check("rst_mid_out_rdy", io_out_rdy, 1);
      check("rst_mid_err", io_err, 5'b10000);
      check("rst_mid_tx_data", tx_data, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
